// File: rtl/rx_serial_pkg.sv
// Shared types and constants for the framed serial receiver.
// State encoding, default geometry and the idle line level.
package rx_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int WIDTH_DEF = 4;
  localparam int DIV_DEF   = 8;

  localparam int CNT_W  = $clog2(DIV_DEF);
  localparam int BCNT_W = $clog2(WIDTH_DEF);

  localparam logic RX_IDLE_LVL = 1'b1;

  function automatic int clog2_min1(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rx_serial_nib_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RST_VAL so the output starts at the idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/rx_serial_nib.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, stop bit.
// Presents the word with a one-cycle valid, or a one-cycle framing error.
module rx_serial_nib
  import rx_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             ferr,
  output logic             busy
);

  localparam int CW = clog2_min1(DIV);
  localparam int BW = clog2_min1(WIDTH);

  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

  logic rx_s;

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  sync2 #(
    .RST_VAL (RX_IDLE_LVL)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s != RX_IDLE_LVL) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s == RX_IDLE_LVL) begin
            state_d = IDLE;
          end else begin
            bcnt_d  = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[WIDTH-1:1]};
          if (bcnt_q == BCNT_LAST) begin
            state_d = STOP;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s == RX_IDLE_LVL) begin
            dout_d  = shreg_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        // Stay here while the line is held low so only one error is flagged.
        cnt_d = '0;
        if (rx_s == RX_IDLE_LVL) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rx_serial_nib.sv
// Directed bench for rx_serial_nib: framing, latency, glitches,
// framing errors and mid-frame reset.
module tb_rx_serial_nib;

  localparam int WIDTH = 4;
  localparam int DIV   = 8;
  localparam int LAT   = 47;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             ferr;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int fcnt     = 0;
  int both     = 0;
  int vcyc     = 0;
  int busy_lo  = 0;
  logic [WIDTH-1:0] vq[$];

  rx_serial_nib #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .dout  (dout),
    .valid (valid),
    .ferr  (ferr),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(dout);
      vcyc = cyc;
    end
    if (ferr) fcnt++;
    if (valid && ferr) both++;
  end

  task automatic hold_bit();
    repeat (DIV) begin
      @(negedge clk);
      if (cyc - t0 >= 4 && cyc - t0 <= LAT - 1 && !busy) busy_lo++;
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop);
    rx = 1'b0;
    t0 = cyc;
    hold_bit();
    for (int i = 0; i < WIDTH; i++) begin
      rx = d[i];
      hold_bit();
    end
    rx = stop;
    hold_bit();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = ~rx;
      #1;
      if ({dout, valid, ferr, busy} !== 7'd0) begin
        failures++;
        $display("FAIL reset_hold got=%b exp=0", {dout, valid, ferr, busy});
      end
      checks++;
    end
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    if ({dout, valid, ferr, busy} !== 7'd0) begin
      failures++;
      $display("FAIL reset_release got=%b exp=0", {dout, valid, ferr, busy});
    end
    checks++;
  endtask

  task automatic test_good_frame();
    int v0;
    int f0;
    v0 = vq.size();
    f0 = fcnt;
    busy_lo = 0;
    send_frame(4'hA, 1'b1);
    repeat (4) @(negedge clk);
    if (vq.size() - v0 !== 1) begin
      failures++;
      $display("FAIL good_vcnt got=%0d exp=1", vq.size() - v0);
    end
    checks++;
    if (vq.size() > v0) begin
      if (vq[v0] !== 4'hA) begin
        failures++;
        $display("FAIL good_data got=%h exp=a", vq[v0]);
      end
      checks++;
    end
    if (dout !== 4'hA) begin
      failures++;
      $display("FAIL good_dout got=%h exp=a", dout);
    end
    checks++;
    if (vcyc - t0 !== LAT) begin
      failures++;
      $display("FAIL good_latency got=%0d exp=%0d", vcyc - t0, LAT);
    end
    checks++;
    if (fcnt !== f0 || busy_lo !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL good_flags got=ferr%0d/busylo%0d/busy%b exp=0/0/0",
               fcnt - f0, busy_lo, busy);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = vq.size();
    send_frame(4'h3, 1'b1);
    send_frame(4'hC, 1'b1);
    repeat (4) @(negedge clk);
    if (vq.size() - v0 !== 2) begin
      failures++;
      $display("FAIL b2b_vcnt got=%0d exp=2", vq.size() - v0);
    end else begin
      if (vq[v0] !== 4'h3 || vq[v0+1] !== 4'hC) begin
        failures++;
        $display("FAIL b2b_data got=%h,%h exp=3,c", vq[v0], vq[v0+1]);
      end
    end
    checks++;
    if (vcyc - t0 !== LAT || dout !== 4'hC) begin
      failures++;
      $display("FAIL b2b_second got=lat%0d/dout%h exp=lat%0d/dout c",
               vcyc - t0, dout, LAT);
    end
    checks++;
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    v0 = vq.size();
    f0 = fcnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_start got=%b exp=1", busy);
    end
    checks++;
    rx = 1'b1;
    repeat (12) @(negedge clk);
    if (vq.size() !== v0 || fcnt !== f0 || dout !== 4'hC || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_abort got=v%0d/f%0d/dout%h/busy%b exp=0/0/c/0",
               vq.size() - v0, fcnt - f0, dout, busy);
    end
    checks++;
  endtask

  task automatic test_framing_error();
    int v0;
    int f0;
    v0 = vq.size();
    f0 = fcnt;
    send_frame(4'h5, 1'b0);
    repeat (20) @(negedge clk);
    if (fcnt - f0 !== 1 || vq.size() !== v0) begin
      failures++;
      $display("FAIL ferr_pulse got=f%0d/v%0d exp=1/0", fcnt - f0, vq.size() - v0);
    end
    checks++;
    if (dout !== 4'hC || busy !== 1'b1) begin
      failures++;
      $display("FAIL ferr_break got=dout%h/busy%b exp=c/1", dout, busy);
    end
    checks++;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (busy !== 1'b0 || fcnt - f0 !== 1) begin
      failures++;
      $display("FAIL ferr_recover got=busy%b/f%0d exp=0/1", busy, fcnt - f0);
    end
    checks++;
    v0 = vq.size();
    send_frame(4'h6, 1'b1);
    repeat (4) @(negedge clk);
    if (vq.size() - v0 !== 1 || dout !== 4'h6) begin
      failures++;
      $display("FAIL ferr_next got=v%0d/dout%h exp=1/6", vq.size() - v0, dout);
    end
    checks++;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    logic [WIDTH-1:0] f;
    f = 4'hF;
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = f[0];
    repeat (DIV) @(negedge clk);
    rx = f[1];
    repeat (DIV) @(negedge clk);
    rx = f[2];
    repeat (DIV / 2) @(negedge clk);
    if (busy !== 1'b1 || dout !== 4'h6) begin
      failures++;
      $display("FAIL mid_before got=busy%b/dout%h exp=1/6", busy, dout);
    end
    checks++;
    #2;
    reset = 1'b0;
    #1;
    if ({dout, valid, ferr, busy} !== 7'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=0", {dout, valid, ferr, busy});
    end
    checks++;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    v0 = vq.size();
    send_frame(4'h9, 1'b1);
    repeat (4) @(negedge clk);
    if (vq.size() - v0 !== 1 || dout !== 4'h9 || vcyc - t0 !== LAT) begin
      failures++;
      $display("FAIL mid_fresh got=v%0d/dout%h/lat%0d exp=1/9/%0d",
               vq.size() - v0, dout, vcyc - t0, LAT);
    end
    checks++;
  endtask

  task automatic test_exclusive();
    if (both !== 0) begin
      failures++;
      $display("FAIL valid_ferr_overlap got=%0d exp=0", both);
    end
    checks++;
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_serial_nib.md
Name: rx_serial_nib

Overview:
- Serial-to-parallel receiver that captures an asynchronous framed bit stream (start bit, WIDTH data bits LSB first, stop bit) and presents a WIDTH-bit word plus a one-cycle valid strobe.
- Sits directly upstream of the 4-bit D-register stage: dout drives its D bus, valid drives its enable, so the register captures each good word.
- Also reports framing errors and a busy flag for lab-board LEDs.

Parameters:
- WIDTH, 4, number of data bits per frame (must match downstream register width).
- DIV, 8, clock cycles per serial bit; even, at least 4.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset); single clock domain.
- rx  input  1  serial line, idle high, asynchronous to clk.
- dout  output  WIDTH  last correctly received word; held between frames.
- valid  output  1  one-cycle pulse when dout is updated with a good word.
- ferr  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, immediate, no clock needed): state=IDLE; dout=0; valid=0; ferr=0; busy=0; bit counter, cycle counter and shift register=0; both synchroniser flops=1 (line idle).
- rx passes through a 2-flop synchroniser → rx_s. All decisions use rx_s only. Raw rx to rx_s latency is 2 cycles.
- Cycle counter cnt counts 0..DIV-1. Bit counter bcnt counts 0..WIDTH-1.
- IDLE: cnt=0. If rx_s==0, go to START.
- START: cnt increments. At cnt==DIV/2-1, sample rx_s:
  - rx_s==1: glitch; return to IDLE, no outputs.
  - rx_s==0: cnt=0, bcnt=0, go to DATA.
- DATA: cnt increments. At cnt==DIV-1 (mid-bit), sample rx_s into shreg: shift right, new bit enters the MSB, so the first bit ends at LSB after WIDTH shifts. Then set cnt=0.
  - bcnt==WIDTH-1: go to STOP.
  - Otherwise bcnt+1.
- STOP: at cnt==DIV-1, sample rx_s:
  - rx_s==1: dout<=shreg, valid=1 for exactly one cycle (the cycle after the sample edge), go to IDLE.
  - rx_s==0: ferr=1 for one cycle, dout unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A line held low never produces repeated errors.
- valid and ferr are registered and never high simultaneously. Both are deasserted in every other cycle.
- Latency: from the rx_s falling edge (IDLE→START), valid asserts after DIV/2 + (WIDTH+1)·DIV + 1 cycles. For DIV=8, WIDTH=4 that is 45 cycles.
- Back-to-back frames: a start bit may begin immediately after the stop sample. IDLE accepts rx_s==0 in the same cycle valid is high.
- Reset mid-frame: frame is abandoned, all outputs go to reset values, dout is cleared to 0.
- rx changes are ignored except at the sample points above.
- Counters never exceed their terminal values. No wrap is possible outside the transitions listed.

Decomposition:
- Shared package rx_serial_pkg:
  - state enum: IDLE, START, DATA, STOP, BREAK (3-bit encoding).
  - localparams CNT_W = clog2(DIV) and BCNT_W = clog2(WIDTH).
  - constant RX_IDLE_LVL = 1'b1.
- One sub-module: sync2 (two-flop synchroniser with active-low asynchronous reset to a parameterised value). Instantiated once for rx.
- FSM, counters and shift register stay in the top module.

Test Plan:
- Reset check: hold reset=0 with rx toggling → dout=0, valid=0, ferr=0, busy=0 throughout. Release → still idle, busy=0.
- Good frame, WIDTH=4, DIV=8: send 0xA as start 0, bits 0,1,0,1, stop 1, each 8 cycles.
  - dout=4'b1010 and valid pulses exactly once, 45 cycles after rx_s falls.
  - ferr stays 0; busy high for the frame duration.
- Back-to-back: 0x3 immediately followed by 0xC, no idle gap → two valid pulses, dout=3 then dout=C. The second frame is not missed.
- Glitch rejection: rx low for 3 cycles then high → START aborts to IDLE; no valid, no ferr, dout unchanged.
- Framing error: send 0x5 with stop bit 0 and hold the line low 20 more cycles.
  - ferr pulses once; dout keeps its previous value; state stays BREAK until rx returns high.
  - A following good 0x6 frame then yields valid with dout=6.
- Reset mid-frame: assert reset during the third data bit of 0xF → outputs return to reset values at once. After release, a fresh 0x9 frame gives dout=9, valid=1.
